adpll_lock_ctrl: RTL and testbench



---
 rtl/adpll_lock_ctrl.sv | 88 ++++++++
 tb/tb_adpll_lock_ctrl.sv | 111 +++++++++++
 2 files changed

// File: rtl/adpll_lock_ctrl.sv
// adpll_lock_ctrl: ADPLL acquisition/lock sequencer that evaluates corrections over fixed reference windows
module adpll_lock_ctrl #(
  parameter int WIN          = 16,
  parameter int COARSE_TH    = 4,
  parameter int LOCK_TH      = 1,
  parameter int LOCK_WINS    = 4,
  parameter int UNLOCK_TH    = 4,
  parameter int TIMEOUT_WINS = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       ref_rise,
  input  logic       add_pulse,
  input  logic       sub_pulse,
  output logic       loop_en,
  output logic [1:0] gain_sel,
  output logic       locked,
  output logic       lock_lost,
  output logic       acq_fail,
  output logic [1:0] state
);
  localparam int RW = $clog2(WIN);
  localparam int GW = $clog2(LOCK_WINS + 1);
  localparam int WW = $clog2(TIMEOUT_WINS + 1);
  typedef enum logic [1:0] {IDLE, COARSE, FINE, LOCKED} st_t;
  st_t st, nst;
  logic [RW-1:0] ref_cnt;
  logic [15:0] corr_cnt, c;
  logic [GW-1:0] good_cnt, gn;
  logic [WW-1:0] win_cnt, wn;
  logic corr, we, acq, good, fine_ok, lock_in, lost, tmo;
  assign state = st;
  always_comb begin
    corr = add_pulse | sub_pulse;
    we = ref_rise && ref_cnt == RW'(WIN - 1);
    c = corr_cnt + 16'(corr && corr_cnt != 16'hffff);
    gn = good_cnt + 1'b1;
    wn = win_cnt + 1'b1;
    acq = st == COARSE || st == FINE;
    good = c <= 16'(LOCK_TH);
    fine_ok = c <= 16'(COARSE_TH);
    lock_in = st == FINE && we && good && gn == GW'(LOCK_WINS);
    lost = st == LOCKED && we && c >= 16'(UNLOCK_TH);
    tmo = acq && we && wn == WW'(TIMEOUT_WINS) && !lock_in;
    nst = st;
    if (st == IDLE)
      nst = COARSE;
    else if (lock_in)
      nst = LOCKED;
    else if (tmo || lost || (st == FINE && we && !fine_ok))
      nst = COARSE;
    else if (st == COARSE && we && fine_ok)
      nst = FINE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      st <= IDLE;
      loop_en <= 1'b0;
      gain_sel <= 2'b00;
      locked <= 1'b0;
      lock_lost <= 1'b0;
      acq_fail <= 1'b0;
      ref_cnt <= '0;
      corr_cnt <= '0;
      good_cnt <= '0;
      win_cnt <= '0;
    end else begin
      st <= nst;
      loop_en <= 1'b1;
      gain_sel <= nst == COARSE ? 2'b10 : nst == FINE ? 2'b01 : 2'b00;
      locked <= nst == LOCKED;
      lock_lost <= lost;
      acq_fail <= tmo;
      if (st == IDLE || tmo) begin
        ref_cnt <= '0;
        corr_cnt <= '0;
        good_cnt <= '0;
        win_cnt <= '0;
      end else begin
        ref_cnt <= we ? '0 : ref_cnt + RW'(ref_rise);
        corr_cnt <= we ? '0 : c;
        good_cnt <= we ? (st == FINE && good ? gn : '0) : good_cnt;
        win_cnt <= lock_in || lost ? '0 : we && acq ? wn : win_cnt;
      end
    end
  end
endmodule

// File: tb/tb_adpll_lock_ctrl.sv
// tb_adpll_lock_ctrl: directed-vector bench for the ADPLL lock sequencer
module tb_adpll_lock_ctrl;
  logic clk = 1'b0;
  logic rst_n, enable, ref_rise, add_pulse, sub_pulse;
  logic loop_en, locked, lock_lost, acq_fail;
  logic [1:0] gain_sel, state;
  logic [7:0] outs;
  int total = 0;
  int bad = 0;
  adpll_lock_ctrl #(.TIMEOUT_WINS(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ref_rise(ref_rise),
    .add_pulse(add_pulse), .sub_pulse(sub_pulse), .loop_en(loop_en),
    .gain_sel(gain_sel), .locked(locked), .lock_lost(lock_lost),
    .acq_fail(acq_fail), .state(state)
  );
  always #5 clk = ~clk;
  assign outs = {state, loop_en, gain_sel, locked, lock_lost, acq_fail};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic r, input logic a, input logic s);
    ref_rise = r;
    add_pulse = a;
    sub_pulse = s;
    @(posedge clk);
    #1;
  endtask
  task automatic win(input int n, input bit on_we);
    int k;
    k = on_we ? n - 1 : n;
    for (int i = 0; i < 128; i++)
      cyc(i % 8 == 7, (i < k) || (on_we && i == 127), 1'b0);
  endtask
  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    ref_rise = 1'b0;
    add_pulse = 1'b0;
    sub_pulse = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0);
      chk("reset_outs", 32'(outs), 32'h00);
    end
    rst_n = 1'b1;
    enable = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    chk("enable_coarse", 32'(outs), {24'h0, 2'd1, 1'b1, 2'b10, 3'b000});
    win(10, 1'b0);
    chk("w1_coarse", 32'(state), 32'd1);
    win(10, 1'b0);
    chk("w2_coarse", 32'(state), 32'd1);
    win(3, 1'b0);
    chk("w3_fine", 32'(outs), {24'h0, 2'd2, 1'b1, 2'b01, 3'b000});
    for (int w = 4; w < 7; w++) begin
      win(0, 1'b0);
      chk("w4_6_fine", 32'(state), 32'd2);
    end
    win(0, 1'b0);
    chk("w7_locked", 32'(outs), {24'h0, 2'd3, 1'b1, 2'b00, 3'b100});
    win(3, 1'b0);
    chk("locked_c3_stays", 32'(outs), {24'h0, 2'd3, 1'b1, 2'b00, 3'b100});
    win(4, 1'b1);
    chk("lost_pulse", 32'(outs), {24'h0, 2'd1, 1'b1, 2'b10, 3'b010});
    cyc(1'b0, 1'b0, 1'b0);
    chk("lost_one_cycle", 32'(outs), {24'h0, 2'd1, 1'b1, 2'b10, 3'b000});
    win(3, 1'b0);
    chk("refine", 32'(state), 32'd2);
    for (int w = 0; w < 3; w++)
      win(0, 1'b0);
    chk("good_cnt3", 32'(dut.good_cnt), 32'd3);
    chk("still_fine", 32'(state), 32'd2);
    win(6, 1'b0);
    chk("fallback_state", 32'(outs), {24'h0, 2'd1, 1'b1, 2'b10, 3'b000});
    chk("fallback_good", 32'(dut.good_cnt), 32'd0);
    win(10, 1'b0);
    win(10, 1'b0);
    chk("pre_timeout", 32'(acq_fail), 32'd0);
    win(10, 1'b0);
    chk("timeout1", 32'(outs), {24'h0, 2'd1, 1'b1, 2'b10, 3'b001});
    cyc(1'b0, 1'b0, 1'b0);
    chk("timeout1_one_cycle", 32'(acq_fail), 32'd0);
    for (int w = 0; w < 7; w++) begin
      win(5, 1'b0);
      chk("c5_stays_coarse", 32'(outs), {24'h0, 2'd1, 1'b1, 2'b10, 3'b000});
    end
    win(3, 1'b0);
    chk("timeout_beats_fine", 32'(outs), {24'h0, 2'd1, 1'b1, 2'b10, 3'b001});
    win(3, 1'b0);
    chk("fine_again", 32'(state), 32'd2);
    for (int i = 0; i < 20; i++)
      cyc(i % 8 == 7, i < 2, 1'b0);
    enable = 1'b0;
    cyc(1'b0, 1'b1, 1'b0);
    chk("drop_idle", 32'(outs), 32'h00);
    chk("drop_counters", {dut.corr_cnt, 8'(dut.ref_cnt), 8'(dut.win_cnt)}, 32'h0);
    enable = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    chk("reenable", 32'(state), 32'd1);
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b1, 1'b1);
    chk("both_pulses", 32'(dut.corr_cnt), 32'd3);
    win(0, 1'b0);
    chk("both_window_fine", 32'(state), 32'd2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
